// File: rtl/timer_drv_pkg.sv
// Shared definitions for the timer driver: FSM states, timer register map
// and control register bit positions.
package timer_drv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_P0,
        WR_P1,
        WR_P2,
        WR_P3,
        WR_CTRL,
        RUN,
        CLR_ST,
        STOP,
        SNAP_WR,
        SNAP_RD0,
        SNAP_RD1,
        SNAP_RD2,
        SNAP_RD3,
        SNAP_CAP
    } state_t;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CONTROL = 4'd1;
    localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
    localparam logic [3:0] ADDR_SNAP0   = 4'd6;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_STOP_WORD = 16'd1 << CTRL_STOP;

    function automatic logic [15:0] ctrl_start_word(input logic cont);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = 1'b1;
        w[CTRL_START] = 1'b1;
        w[CTRL_CONT]  = cont;
        return w;
    endfunction

endpackage

// File: rtl/timer_driver.sv
// Bus-master FSM that programs, services, stops and snapshots a
// memory-mapped interval timer over a 16-bit fixed-latency bus.
module timer_driver
    import timer_drv_pkg::*;
#(
    parameter bit          AUTO_START     = 1'b0,
    parameter logic [63:0] DEFAULT_PERIOD = 64'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [3:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        irq,
    input  logic        cfg_start,
    input  logic [63:0] cfg_period,
    input  logic        cfg_continuous,
    input  logic        stop_req,
    input  logic        snap_req,
    output logic        cfg_done,
    output logic        tick,
    output logic        snap_valid,
    output logic [63:0] snap_value,
    output logic        busy
);

    state_t      state;
    logic        cfg_pend;
    logic        stop_pend;
    logic        snap_pend;
    logic [63:0] period_lat;
    logic        cont_lat;
    logic [63:0] period_act;
    logic        cont_act;
    logic        auto_done;
    logic [47:0] snap_buf;

    // A request can be acted on in the very cycle it arrives, before its flag is visible.
    logic        cfg_eff;
    logic        stop_eff;
    logic        snap_eff;
    logic [63:0] period_eff;
    logic        cont_eff;

    assign cfg_eff    = cfg_pend | cfg_start;
    assign stop_eff   = stop_pend | stop_req;
    assign snap_eff   = snap_pend | snap_req;
    assign period_eff = cfg_start ? cfg_period : period_lat;
    assign cont_eff   = cfg_start ? cfg_continuous : cont_lat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            av_address    <= '0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= '0;
            cfg_pend      <= 1'b0;
            stop_pend     <= 1'b0;
            snap_pend     <= 1'b0;
            period_lat    <= '0;
            cont_lat      <= 1'b0;
            period_act    <= '0;
            cont_act      <= 1'b0;
            auto_done     <= 1'b0;
            snap_buf      <= '0;
            cfg_done      <= 1'b0;
            tick          <= 1'b0;
            snap_valid    <= 1'b0;
            snap_value    <= '0;
            busy          <= 1'b0;
        end else begin
            av_address    <= '0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_writedata  <= '0;
            cfg_done      <= 1'b0;
            tick          <= 1'b0;
            snap_valid    <= 1'b0;

            if (cfg_start) begin
                cfg_pend   <= 1'b1;
                period_lat <= cfg_period;
                cont_lat   <= cfg_continuous;
            end
            if (stop_req) stop_pend <= 1'b1;
            if (snap_req) snap_pend <= 1'b1;

            case (state)
                IDLE, RUN: begin
                    if (state == IDLE && AUTO_START && !auto_done) begin
                        auto_done     <= 1'b1;
                        period_act    <= DEFAULT_PERIOD;
                        cont_act      <= 1'b1;
                        state         <= WR_P0;
                        busy          <= 1'b1;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_address    <= ADDR_PERIOD0;
                        av_writedata  <= DEFAULT_PERIOD[15:0];
                    end else if (state == RUN && irq) begin
                        state         <= CLR_ST;
                        busy          <= 1'b1;
                        tick          <= 1'b1;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_address    <= ADDR_STATUS;
                    end else if (cfg_eff) begin
                        cfg_pend      <= 1'b0;
                        period_act    <= period_eff;
                        cont_act      <= cont_eff;
                        state         <= WR_P0;
                        busy          <= 1'b1;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_address    <= ADDR_PERIOD0;
                        av_writedata  <= period_eff[15:0];
                    end else if (state == RUN && stop_eff) begin
                        stop_pend     <= 1'b0;
                        snap_pend     <= 1'b0;
                        state         <= STOP;
                        busy          <= 1'b1;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_address    <= ADDR_CONTROL;
                        av_writedata  <= CTRL_STOP_WORD;
                    end else if (state == RUN && snap_eff) begin
                        snap_pend     <= 1'b0;
                        state         <= SNAP_WR;
                        busy          <= 1'b1;
                        av_chipselect <= 1'b1;
                        av_write_n    <= 1'b0;
                        av_address    <= ADDR_SNAP0;
                    end
                end
                WR_P0: begin
                    state         <= WR_P1;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_address    <= ADDR_PERIOD0 + 4'd1;
                    av_writedata  <= period_act[31:16];
                end
                WR_P1: begin
                    state         <= WR_P2;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_address    <= ADDR_PERIOD0 + 4'd2;
                    av_writedata  <= period_act[47:32];
                end
                WR_P2: begin
                    state         <= WR_P3;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_address    <= ADDR_PERIOD0 + 4'd3;
                    av_writedata  <= period_act[63:48];
                end
                WR_P3: begin
                    state         <= WR_CTRL;
                    av_chipselect <= 1'b1;
                    av_write_n    <= 1'b0;
                    av_address    <= ADDR_CONTROL;
                    av_writedata  <= ctrl_start_word(cont_act);
                end
                WR_CTRL: begin
                    state    <= RUN;
                    busy     <= 1'b0;
                    cfg_done <= 1'b1;
                end
                CLR_ST: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
                STOP: begin
                    snap_pend <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                SNAP_WR: begin
                    state         <= SNAP_RD0;
                    av_chipselect <= 1'b1;
                    av_address    <= ADDR_SNAP0;
                end
                SNAP_RD0: begin
                    state         <= SNAP_RD1;
                    av_chipselect <= 1'b1;
                    av_address    <= ADDR_SNAP0 + 4'd1;
                end
                // Read data trails its address by one cycle, so each state stores the previous word.
                SNAP_RD1: begin
                    state          <= SNAP_RD2;
                    snap_buf[15:0] <= av_readdata;
                    av_chipselect  <= 1'b1;
                    av_address     <= ADDR_SNAP0 + 4'd2;
                end
                SNAP_RD2: begin
                    state           <= SNAP_RD3;
                    snap_buf[31:16] <= av_readdata;
                    av_chipselect   <= 1'b1;
                    av_address      <= ADDR_SNAP0 + 4'd3;
                end
                SNAP_RD3: begin
                    state           <= SNAP_CAP;
                    snap_buf[47:32] <= av_readdata;
                end
                SNAP_CAP: begin
                    state      <= RUN;
                    busy       <= 1'b0;
                    snap_value <= {av_readdata, snap_buf};
                    snap_valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_driver.md
TIMER_DRIVER -- requirements
Module: timer_driver

Interface
REQ-001 SHALL have parameter AUTO_START, default 0; when 1, the block configures the timer once after reset using DEFAULT_PERIOD and continuous mode.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 64'd49999; the period loaded by an AUTO_START configuration.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port av_address, output, 4 bits: timer halfword address (0 status, 1 control, 2-5 period, 6-9 snapshot).
REQ-006 SHALL have port av_chipselect, output, 1 bit: bus access active.
REQ-007 SHALL have port av_write_n, output, 1 bit: 0 write, 1 read.
REQ-008 SHALL have port av_writedata, output, 16 bits: write data.
REQ-009 SHALL have port av_readdata, input, 16 bits: read data, valid on the cycle after the address is presented (fixed latency 1, no waitrequest).
REQ-010 SHALL have port irq, input, 1 bit: timer interrupt, level, registered at source.
REQ-011 SHALL have port cfg_start, input, 1 bit: pulse; request programming and start of the timer.
REQ-012 SHALL have port cfg_period, input, 64 bits: period, sampled on the cfg_start cycle.
REQ-013 SHALL have port cfg_continuous, input, 1 bit: continuous-mode bit, sampled with cfg_period.
REQ-014 SHALL have port stop_req, input, 1 bit: pulse; request to stop the timer.
REQ-015 SHALL have port snap_req, input, 1 bit: pulse; request a counter snapshot.
REQ-016 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when the control write completes.
REQ-017 SHALL have port tick, output, 1 bit: one-cycle pulse per serviced timeout.
REQ-018 SHALL have port snap_valid, output, 1 bit: one-cycle pulse; snap_value is valid.
REQ-019 SHALL have port snap_value, output, 64 bits: captured counter, held until the next capture.
REQ-020 SHALL have port busy, output, 1 bit: high in every state except IDLE and RUN.

Function
REQ-021 SHALL drive all av_* outputs from registers; idle bus SHALL be chipselect=0, write_n=1, address=0, writedata=0.
REQ-022 SHALL latch cfg_start, stop_req and snap_req into pending flags (any state); each flag clears on the cycle its sequence starts; a new cfg_start SHALL overwrite the latched period/mode.
REQ-023 SHALL implement states IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR_ST, STOP, SNAP_WR, SNAP_RD0-3, SNAP_CAP.
REQ-024 Arbitration in RUN, highest first: irq high -> CLR_ST; cfg pending -> WR_P0; stop pending -> STOP; snap pending -> SNAP_WR. In IDLE only a pending cfg is honoured.
REQ-025 WR_P0..WR_P3 SHALL each write one cycle to addresses 2..5 with period bits [15:0], [31:16], [47:32], [63:48].
REQ-026 WR_CTRL SHALL write address 1 with 16'h0005 | (continuous<<1), i.e. START=1, ITO=1; the next cycle SHALL pulse cfg_done, and the state SHALL be RUN.
REQ-027 CLR_ST SHALL write address 0, data 0, for one cycle with tick=1 in that same cycle, then return to RUN; irq is not re-sampled until RUN.
REQ-028 STOP SHALL write address 1, data 16'h0008, for one cycle, then go to IDLE; pending snap SHALL be discarded.
REQ-029 SNAP_WR SHALL write address 6, data 0; SNAP_RD0-3 SHALL read addresses 6..9 on consecutive cycles; each av_readdata SHALL be captured on the cycle after its address, the final one in SNAP_CAP.
REQ-030 snap_valid SHALL pulse the cycle after SNAP_CAP, i.e. 7 cycles after the snap_req cycle when accepted immediately; snap_value SHALL update atomically with the pulse.
REQ-031 Sequences SHALL be non-interruptible; requests arriving mid-sequence SHALL remain pending.
REQ-032 irq high in IDLE SHALL be ignored.

Reset
REQ-033 On reset_n low: state IDLE (or WR_P0 entered on the first cycle after release if AUTO_START=1), bus idle, all pending flags 0, cfg_done/tick/snap_valid/busy 0, snap_value 0, latched period 0.
REQ-034 Reset mid-sequence SHALL abort immediately with no partial write cycle emitted after release.

Structure
REQ-035 A shared package timer_drv_pkg SHALL hold the state enum, register address constants (STATUS 0, CONTROL 1, PERIOD0 2, SNAP0 6), and control bit positions (ITO 0, CONT 1, START 2, STOP 3).
REQ-036 A single FSM module SHALL be used, with no sub-module.

Verification
REQ-037 Scenario: cfg_start with period 64'h0000_0000_0001_86A0, cont=1 -> writes (2,86A0), (3,0001), (4,0), (5,0), (1,0007) on cycles 1-5, then cfg_done on cycle 6.
REQ-038 Scenario: in RUN, irq rises -> next cycle write (0,0000) with tick=1; irq drops -> exactly one tick.
REQ-039 Scenario: irq and snap_req in the same cycle -> CLR_ST first, then the snapshot sequence; snap_valid 2 cycles later than the uncontended case.
REQ-040 Scenario: timer model holds counter 64'h0123_4567_89AB_CDEF at snapshot -> snap_value equals that value, snap_valid pulses once.
REQ-041 Scenario: stop_req in RUN -> write (1,0008), state IDLE; subsequent irq produces no tick.
REQ-042 Scenario: reset asserted during WR_P2 -> chipselect 0 next cycle; with AUTO_START=1, after release the writes (2,C34F), (3,0), (4,0), (5,0), (1,0007) occur.
